// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, flag struct and FSM states shared by seq_alu and alu_iter
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NOT  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_EQ   = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIVU = 4'd12,
    OP_REMU = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic err;
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_long(input alu_op_e o);
    return (o == OP_MUL) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  function automatic logic is_div_op(input alu_op_e o);
    return (o == OP_DIVU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - shared shift-add multiplier / restoring divider datapath
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             busy,
  input  logic [CW-1:0]    counter,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);

  // acc_q: product accumulator or partial remainder
  // opa_q: shifted multiplicand or dividend/quotient shift register
  // opb_q: shifted multiplier or divisor
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [WIDTH:0]   rem_shift, add_x, add_y;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic             step;

  assign step      = busy && (counter < CW'(WIDTH));
  assign rem_shift = {acc_q, opa_q[WIDTH-1]};

  // One adder serves both ops; division subtracts via a + ~b + 1.
  assign add_x     = is_div ? rem_shift : {1'b0, acc_q};
  assign add_y     = is_div ? ~{1'b0, opb_q} : {1'b0, opa_q};
  assign sum       = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};
  assign no_borrow = sum[WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      opa_q <= a;
      opb_q <= b;
    end else if (step) begin
      if (is_div) begin
        acc_q <= no_borrow ? sum[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        opa_q <= {opa_q[WIDTH-2:0], no_borrow};
      end else begin
        if (opb_q[0]) acc_q <= sum[WIDTH-1:0];
        opa_q <= {opa_q[WIDTH-2:0], 1'b0};
        opb_q <= {1'b0, opb_q[WIDTH-1:1]};
      end
    end
  end

  assign acc = acc_q;
  assign quo = opa_q;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle integer ALU with valid/ready request and result handshakes
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state, nstate;
  alu_op_e          op_c, op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q, res_c, iter_acc, iter_quo, iter_res;
  alu_flags_t       flags_q, fl_c, fl_long;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;
  logic             accept;

  assign op_c   = alu_op_e'(op);
  assign accept = in_valid && (state == ST_IDLE);
  assign sh     = b[SHW-1:0];
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_c = '0;
    fl_c  = '0;
    case (op_c)
      OP_ADD: begin
        res_c  = add_w[WIDTH-1:0];
        fl_c.c = add_w[WIDTH];
        fl_c.v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c  = sub_w[WIDTH-1:0];
        fl_c.c = sub_w[WIDTH];
        fl_c.v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  res_c = ~a;
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_EQ:   res_c = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLL:  res_c = a << sh;
      OP_SRL:  res_c = a >> sh;
      OP_SRA:  res_c = WIDTH'($signed(a) >>> sh);
      OP_MUL, OP_DIVU, OP_REMU: res_c = '0;
      default: fl_c.err = 1'b1;
    endcase
    fl_c.z = (res_c == '0);
    fl_c.n = res_c[WIDTH-1];
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (accept) nstate = is_long(op_c) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt_q == CW'(WIDTH - 1)) nstate = ST_DONE;
      ST_DONE: if (out_ready) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        op_q     <= op_c;
        result_q <= res_c;
        flags_q  <= fl_c;
        cnt_q    <= '0;
      end else if (state == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  alu_iter #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .is_div  (is_div_op(op_q)),
    .busy    (state == ST_BUSY),
    .counter (cnt_q),
    .a       (a),
    .b       (b),
    .acc     (iter_acc),
    .quo     (iter_quo)
  );

  // Long-op results are read straight from the iterator registers, which freeze outside BUSY.
  assign iter_res = (op_q == OP_DIVU) ? iter_quo : iter_acc;
  always_comb begin
    fl_long   = '0;
    fl_long.z = (iter_res == '0);
    fl_long.n = iter_res[WIDTH-1];
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = is_long(op_q) ? iter_res : result_q;
  assign flags     = is_long(op_q) ? fl_long : flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed vector bench for seq_alu at WIDTH=8
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic [4:0] flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] fl;
    int         lat;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one request, scramble the operands after accept, wait for out_valid.
  task automatic do_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                       output logic [7:0] r, output logic [4:0] f, output int lat,
                       output logic busy_ok);
    @(negedge clk);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~xa; b = xb ^ 8'h5A; op = 4'h3;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    r = result;
    f = flags;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] r, r0;
    logic [4:0] f, f0;
    int         lat;
    logic       busy_ok;
    int         stale;

    //            op     a      b      res    {err,v,c,n,z} lat
    tbl[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b01010, 1};
    tbl[1]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 5'b00010, 1};
    tbl[2]  = '{4'd1,  8'h05, 8'h05, 8'h00, 5'b00101, 1};
    tbl[3]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b00101, 1};
    tbl[4]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b01100, 1};
    tbl[5]  = '{4'd2,  8'h0F, 8'h00, 8'hF0, 5'b00010, 1};
    tbl[6]  = '{4'd3,  8'hF0, 8'h3C, 8'h30, 5'b00000, 1};
    tbl[7]  = '{4'd4,  8'hF0, 8'h0F, 8'hFF, 5'b00010, 1};
    tbl[8]  = '{4'd5,  8'hAA, 8'hFF, 8'h55, 5'b00000, 1};
    tbl[9]  = '{4'd6,  8'h80, 8'h01, 8'h01, 5'b00000, 1};
    tbl[10] = '{4'd6,  8'h01, 8'h80, 8'h00, 5'b00001, 1};
    tbl[11] = '{4'd7,  8'h05, 8'h05, 8'h01, 5'b00000, 1};
    tbl[12] = '{4'd7,  8'h05, 8'h06, 8'h00, 5'b00001, 1};
    tbl[13] = '{4'd8,  8'h01, 8'h0F, 8'h80, 5'b00010, 1};
    tbl[14] = '{4'd9,  8'h80, 8'h09, 8'h40, 5'b00000, 1};
    tbl[15] = '{4'd10, 8'h90, 8'h0B, 8'hF2, 5'b00010, 1};
    tbl[16] = '{4'd14, 8'h12, 8'h34, 8'h00, 5'b10001, 1};
    tbl[17] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 5'b10001, 1};
    tbl[18] = '{4'd11, 8'd13, 8'd11, 8'h8F, 5'b00010, 9};
    tbl[19] = '{4'd11, 8'hFF, 8'hFF, 8'h01, 5'b00000, 9};
    tbl[20] = '{4'd12, 8'd200, 8'd7, 8'd28, 5'b00000, 9};
    tbl[21] = '{4'd13, 8'd200, 8'd7, 8'd4,  5'b00000, 9};
    tbl[22] = '{4'd12, 8'd9,  8'd0, 8'hFF, 5'b00010, 9};
    tbl[23] = '{4'd13, 8'd9,  8'd0, 8'd9,  5'b00000, 9};

    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post-reset in_ready", in_ready, 1);

    for (int i = 0; i < 24; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat, busy_ok);
      chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d result", i), r, tbl[i].res);
      chk($sformatf("v%0d flags", i), f, tbl[i].fl);
      chk($sformatf("v%0d in_ready low", i), busy_ok, 1);
      consume();
    end

    // Backpressure: hold DONE for 3 cycles
    do_op(4'd11, 8'd13, 8'd11, r0, f0, lat, busy_ok);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", k), out_valid, 1);
      chk($sformatf("hold%0d in_ready", k), in_ready, 0);
      chk($sformatf("hold%0d result", k), result, 8'h8F);
      chk($sformatf("hold%0d flags", k), flags, 5'b00010);
    end
    consume();
    chk("after consume out_valid", out_valid, 0);
    chk("after consume in_ready", in_ready, 1);

    // out_ready already high on DONE entry: consumed in one cycle
    out_ready = 1'b1;
    @(negedge clk);
    op = 4'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fast out_valid", out_valid, 1);
    chk("fast result", result, 8'd3);
    @(negedge clk);
    chk("fast drained out_valid", out_valid, 0);
    chk("fast drained in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Reset in the middle of a MUL
    @(negedge clk);
    op = 4'd11; a = 8'd13; b = 8'd11; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul rst out_valid", out_valid, 0);
    chk("midmul rst in_ready", in_ready, 1);
    chk("midmul rst result", result, 0);
    chk("midmul rst flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) stale++;
    end
    out_ready = 1'b0;
    chk("midmul no stale result", stale, 0);

    do_op(4'd5, 8'hC3, 8'h0F, r, f, lat, busy_ok);
    chk("post-rst xor result", r, 8'hCC);
    chk("post-rst xor flags", f, 5'b00010);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
